// File: rtl/axi_lite_led_ctrl_slave.sv
// AXI4-Lite slave with four R/W registers (CTRL, PATTERN, PERIOD, SCRATCH)
// driving an LED bank with optional blinking.
module axi_lite_led_ctrl_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_LED_WIDTH        = 8
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_LED_WIDTH-1:0]            led_out
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned LW = C_LED_WIDTH;

    localparam logic [1:0] SEL_CTRL    = 2'd0;
    localparam logic [1:0] SEL_PATTERN = 2'd1;
    localparam logic [1:0] SEL_PERIOD  = 2'd2;
    localparam logic [1:0] SEL_SCRATCH = 2'd3;

    // Protection bits and byte offset within a word carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    logic          aw_held_q, aw_held_d;
    logic [1:0]    aw_sel_q, aw_sel_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [SW-1:0] w_strb_q, w_strb_d;

    logic [DW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] pattern_q, pattern_d;
    logic [DW-1:0] period_q, period_d;
    logic [DW-1:0] scratch_q, scratch_d;

    logic [31:0]   cnt_q, cnt_d;
    logic          phase_q, phase_d;

    logic          awready_d, wready_d, arready_d;
    logic          bvalid_d, rvalid_d;
    logic [DW-1:0] rdata_d;
    logic [LW-1:0] led_d;

    logic          aw_hs, w_hs, ar_hs, wr_fire;
    logic [1:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    // Byte-lane merge of new write data into an existing register value
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_val,
                                            input logic [DW-1:0] new_val,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_val;
        for (int unsigned i = 0; i < SW; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Next-state logic for both AXI channels, register file, blink timer and LEDs
    always_comb begin
        aw_held_d = aw_held_q;
        aw_sel_d  = aw_sel_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ctrl_d    = ctrl_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        bvalid_d  = s00_axi_bvalid;
        rvalid_d  = s00_axi_rvalid;
        rdata_d   = s00_axi_rdata;
        led_d     = '0;

        aw_hs   = s00_axi_awvalid && s00_axi_awready;
        w_hs    = s00_axi_wvalid && s00_axi_wready;
        ar_hs   = s00_axi_arvalid && s00_axi_arready;
        wr_sel  = aw_held_q ? aw_sel_q : s00_axi_awaddr[3:2];
        wr_data = w_held_q ? w_data_q : s00_axi_wdata;
        wr_strb = w_held_q ? w_strb_q : s00_axi_wstrb;
        wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs);

        if (s00_axi_bvalid && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            case (wr_sel)
                SEL_CTRL:    ctrl_d    = merge(ctrl_q, wr_data, wr_strb);
                SEL_PATTERN: pattern_d = merge(pattern_q, wr_data, wr_strb);
                SEL_PERIOD:  period_d  = merge(period_q, wr_data, wr_strb);
                SEL_SCRATCH: scratch_d = merge(scratch_q, wr_data, wr_strb);
            endcase
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_sel_d  = s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = s00_axi_wdata;
                w_strb_d = s00_axi_wstrb;
            end
        end

        // Reconfiguring CTRL or PERIOD restarts the blink from the lit phase
        if (wr_fire && (wr_sel == SEL_CTRL || wr_sel == SEL_PERIOD)) begin
            cnt_d   = 32'd0;
            phase_d = 1'b0;
        end else if (ctrl_q[0] && ctrl_q[1]) begin
            if (cnt_q == period_q) begin
                cnt_d   = 32'd0;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        // Read sees register state before any same-edge write commits
        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (s00_axi_araddr[3:2])
                SEL_CTRL:    rdata_d = ctrl_q;
                SEL_PATTERN: rdata_d = pattern_q;
                SEL_PERIOD:  rdata_d = period_q;
                SEL_SCRATCH: rdata_d = scratch_q;
            endcase
        end else if (s00_axi_rvalid && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end

        if (ctrl_q[0] && (!ctrl_q[1] || !phase_q)) begin
            led_d = pattern_q[LW-1:0];
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held_q       <= 1'b0;
            aw_sel_q        <= 2'd0;
            w_held_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            ctrl_q          <= '0;
            pattern_q       <= '0;
            period_q        <= '0;
            scratch_q       <= '0;
            cnt_q           <= 32'd0;
            phase_q         <= 1'b0;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            s00_axi_arready <= 1'b1;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            led_out         <= '0;
        end else begin
            aw_held_q       <= aw_held_d;
            aw_sel_q        <= aw_sel_d;
            w_held_q        <= w_held_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            ctrl_q          <= ctrl_d;
            pattern_q       <= pattern_d;
            period_q        <= period_d;
            scratch_q       <= scratch_d;
            cnt_q           <= cnt_d;
            phase_q         <= phase_d;
            s00_axi_awready <= awready_d;
            s00_axi_wready  <= wready_d;
            s00_axi_arready <= arready_d;
            s00_axi_bvalid  <= bvalid_d;
            s00_axi_rvalid  <= rvalid_d;
            s00_axi_rdata   <= rdata_d;
            led_out         <= led_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_led_ctrl_slave.sv
// Directed bench for axi_lite_led_ctrl_slave: register access, strobes,
// split AW/W with backpressure, LED drive, blinking and mid-transaction reset.
module tb_axi_lite_led_ctrl_slave;

    logic        clk;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  led_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_data_q[$];
    logic [1:0]  exp_resp_q[$];

    axi_lite_led_ctrl_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .C_LED_WIDTH(8)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .led_out(led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Full write with bready high; led_at_b is led_out on the cycle bvalid is first seen
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [7:0] led_at_b);
        logic aw_ok;
        logic w_ok;
        logic got;
        int   n;
        exp_resp_q.push_back(2'b00);
        @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        bready  = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_ok = awready;
            w_ok  = wready;
            @(negedge clk);
            if (aw_ok) awvalid = 1'b0;
            if (w_ok)  wvalid  = 1'b0;
            n++;
        end
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        got      = 1'b0;
        led_at_b = 8'h00;
        n = 0;
        while (!got && n < 50) begin
            if (bvalid) begin
                got      = 1'b1;
                led_at_b = led_out;
                check($sformatf("bresp@%0h", addr), 32'(bresp), 32'(exp_resp_q.pop_front()));
            end
            @(negedge clk);
            n++;
        end
        check($sformatf("bvalid_seen@%0h", addr), 32'(got), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        logic ok;
        logic done;
        logic got;
        int   n;
        exp_data_q.push_back(exp);
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            ok = arready;
            @(negedge clk);
            if (ok) begin
                arvalid = 1'b0;
                done    = 1'b1;
            end
            n++;
        end
        arvalid = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            if (rvalid) begin
                got = 1'b1;
                check($sformatf("rdata@%0h", addr), rdata, exp_data_q.pop_front());
                check($sformatf("rresp@%0h", addr), 32'(rresp), 32'd0);
            end
            @(negedge clk);
            n++;
        end
        check($sformatf("rvalid_seen@%0h", addr), 32'(got), 32'd1);
    endtask

    initial begin
        logic [7:0] led_b;
        areset  = 1'b1;
        awaddr  = 4'h0;
        awprot  = 3'b000;
        awvalid = 1'b0;
        wdata   = 32'h0;
        wstrb   = 4'h0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = 4'h0;
        arprot  = 3'b000;
        arvalid = 1'b0;
        rready  = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_led",     32'(led_out), 32'd0);

        // Sequential write then read-back of all registers
        for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, led_b);
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 32'(i + 1));

        // Partial strobes
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, led_b);
        axi_write(4'hC, 32'h0000_0000, 4'b0101, led_b);
        axi_read(4'hC, 32'hFF00_FF00);

        // W two cycles ahead of AW, response backpressured for 5 cycles
        @(negedge clk);
        wdata  = 32'h1234_5678;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        bready = 1'b0;
        check("split_wready0", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        check("split_wready_held", 32'(wready),  32'd0);
        check("split_awready",     32'(awready), 32'd1);
        check("split_nobvalid",    32'(bvalid),  32'd0);
        @(negedge clk);
        awaddr  = 4'hC;
        awvalid = 1'b1;
        check("split_awready0", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_bvalid%0d", i),  32'(bvalid),  32'd1);
            check($sformatf("bp_awready%0d", i), 32'(awready), 32'd0);
            check($sformatf("bp_wready%0d", i),  32'(wready),  32'd0);
            check($sformatf("bp_bresp%0d", i),   32'(bresp),   32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bp_bvalid_drop", 32'(bvalid),  32'd0);
        check("bp_awready_up",  32'(awready), 32'd1);
        check("bp_wready_up",   32'(wready),  32'd1);
        axi_read(4'hC, 32'h1234_5678);

        // Static LED drive
        axi_write(4'h0, 32'h0, 4'hF, led_b);
        axi_write(4'h4, 32'hA5, 4'hF, led_b);
        check("led_off_pattern", 32'(led_out), 32'h00);
        axi_write(4'h0, 32'h1, 4'hF, led_b);
        check("led_on_at_b", 32'(led_b),   32'h00);
        check("led_on",      32'(led_out), 32'hA5);
        axi_write(4'h0, 32'h0, 4'hF, led_b);
        check("led_dis_at_b", 32'(led_b),   32'hA5);
        check("led_dis",      32'(led_out), 32'h00);

        // Blinking with PERIOD=4: 5-cycle lit/dark runs
        axi_write(4'h8, 32'd4, 4'hF, led_b);
        axi_write(4'h0, 32'h3, 4'hF, led_b);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("blink%0d", k), 32'(led_out), ((k / 5) % 2 == 0) ? 32'hA5 : 32'h00);
            @(negedge clk);
        end

        // Reset while a response is pending and blinking is active
        awaddr  = 4'hC;
        awvalid = 1'b1;
        wdata   = 32'hDEAD_BEEF;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        bready  = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        areset = 1'b1;
        @(negedge clk);
        check("mid_rst_bvalid",  32'(bvalid),  32'd0);
        check("mid_rst_led",     32'(led_out), 32'd0);
        check("mid_rst_awready", 32'(awready), 32'd1);
        areset = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        check("post_rst_bvalid", 32'(bvalid), 32'd0);
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 32'd0);
        check("post_rst_led", 32'(led_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
